// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch/jump redirect squash,
// and saturating performance counters for stall cycles and redirect events.
module hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int REDIRECT_CYCLES   = 1,
  parameter int CW                = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [4:0]    ID_RS,
  input  logic [4:0]    ID_RT,
  input  logic          ID_UsesRT,
  input  logic          EX_MEM_RDEN,
  input  logic [4:0]    EX_RT,
  input  logic [1:0]    EX_PCSrc,
  output logic          PC_Write,
  output logic          IF_ID_Write,
  output logic          IF_ID_Flush,
  output logic          ID_EX_Flush,
  output logic [CW-1:0] Stall_Count,
  output logic [CW-1:0] Redirect_Count
);

  localparam int CNT_MAX = (LOAD_STALL_CYCLES > REDIRECT_CYCLES) ? LOAD_STALL_CYCLES
                                                                 : REDIRECT_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] LS_RELOAD = CNT_W'(LOAD_STALL_CYCLES - 2);
  localparam logic [CNT_W-1:0] RD_RELOAD = CNT_W'(REDIRECT_CYCLES - 2);

  typedef enum logic [1:0] {RUN, LDSTALL, REDIR} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             lu, rd;
  logic             stall_inc, redir_inc;

  assign lu = EX_MEM_RDEN && (EX_RT != 5'd0) &&
              ((EX_RT == ID_RS) || (ID_UsesRT && (EX_RT == ID_RT)));
  assign rd = (EX_PCSrc != 2'b00);

  // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    PC_Write    = 1'b1;
    IF_ID_Write = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_Flush = 1'b0;
    stall_inc   = 1'b0;
    redir_inc   = 1'b0;

    // A redirect wins in every state: anything younger is on the wrong path.
    if (rd) begin
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
      redir_inc   = 1'b1;
      if (REDIRECT_CYCLES > 1) begin
        state_nx = REDIR;
        cnt_nx   = RD_RELOAD;
      end else begin
        state_nx = RUN;
      end
    end else begin
      unique case (state)
        RUN: begin
          if (lu) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
            stall_inc   = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_nx = LDSTALL;
              cnt_nx   = LS_RELOAD;
            end
          end
        end
        LDSTALL: begin
          PC_Write    = 1'b0;
          IF_ID_Write = 1'b0;
          ID_EX_Flush = 1'b1;
          stall_inc   = 1'b1;
          if (cnt == '0) state_nx = RUN;
          else           cnt_nx   = cnt - CNT_W'(1);
        end
        REDIR: begin
          IF_ID_Flush = 1'b1;
          ID_EX_Flush = 1'b1;
          if (cnt == '0) state_nx = RUN;
          else           cnt_nx   = cnt - CNT_W'(1);
        end
        default: state_nx = RUN;
      endcase
    end

    if (reset) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= RUN;
      cnt            <= '0;
      Stall_Count    <= '0;
      Redirect_Count <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (stall_inc && (Stall_Count != '1))    Stall_Count    <= Stall_Count + CW'(1);
      if (redir_inc && (Redirect_Count != '1)) Redirect_Count <= Redirect_Count + CW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl: a default instance (a) and one
// with LOAD_STALL_CYCLES=3, REDIRECT_CYCLES=2, CW=4 (b) share the same inputs.
module tb_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_rden;
  logic [1:0] ex_pcsrc;

  logic        a_pcw, a_ifw, a_iff, a_idf;
  logic        b_pcw, b_ifw, b_iff, b_idf;
  logic [31:0] a_stall, a_redir;
  logic [3:0]  b_stall, b_redir;
  logic [3:0]  a_ctl, b_ctl;

  int tests  = 0;
  int failed = 0;

  // Control vector order: {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush}
  localparam logic [3:0] CTL_DEF   = 4'b1100;
  localparam logic [3:0] CTL_STALL = 4'b0001;
  localparam logic [3:0] CTL_FLUSH = 4'b1111;
  localparam logic [3:0] CTL_RST   = 4'b0011;

  assign a_ctl = {a_pcw, a_ifw, a_iff, a_idf};
  assign b_ctl = {b_pcw, b_ifw, b_iff, b_idf};

  always #5 clock = ~clock;

  hazard_ctrl dut_a (
    .clock(clock), .reset(reset),
    .ID_RS(id_rs), .ID_RT(id_rt), .ID_UsesRT(id_uses_rt),
    .EX_MEM_RDEN(ex_mem_rden), .EX_RT(ex_rt), .EX_PCSrc(ex_pcsrc),
    .PC_Write(a_pcw), .IF_ID_Write(a_ifw), .IF_ID_Flush(a_iff), .ID_EX_Flush(a_idf),
    .Stall_Count(a_stall), .Redirect_Count(a_redir)
  );

  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .REDIRECT_CYCLES(2), .CW(4)) dut_b (
    .clock(clock), .reset(reset),
    .ID_RS(id_rs), .ID_RT(id_rt), .ID_UsesRT(id_uses_rt),
    .EX_MEM_RDEN(ex_mem_rden), .EX_RT(ex_rt), .EX_PCSrc(ex_pcsrc),
    .PC_Write(b_pcw), .IF_ID_Write(b_ifw), .IF_ID_Flush(b_iff), .ID_EX_Flush(b_idf),
    .Stall_Count(b_stall), .Redirect_Count(b_redir)
  );

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    ex_mem_rden = 1'b0; ex_rt = 5'd0; ex_pcsrc = 2'b00;
  endtask

  task automatic set_lu();
    ex_mem_rden = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    set_lu();
    ex_pcsrc = 2'b01;
    #1;
    tests++; if (a_ctl !== CTL_RST) begin failed++; $display("FAIL reset_ctl_a got %b want %b", a_ctl, CTL_RST); end
    tests++; if (b_ctl !== CTL_RST) begin failed++; $display("FAIL reset_ctl_b got %b want %b", b_ctl, CTL_RST); end
    repeat (2) @(posedge clock);
    #1;
    tests++; if (a_stall !== 32'd0 || a_redir !== 32'd0) begin failed++; $display("FAIL reset_cnt_a got %0d/%0d want 0/0", a_stall, a_redir); end
    tests++; if (b_stall !== 4'd0 || b_redir !== 4'd0) begin failed++; $display("FAIL reset_cnt_b got %0d/%0d want 0/0", b_stall, b_redir); end
    clear_inputs();
    reset = 1'b0;
    #1;
    tests++; if (a_ctl !== CTL_DEF) begin failed++; $display("FAIL post_reset_ctl got %b want %b", a_ctl, CTL_DEF); end
  endtask

  task automatic test_load_use();
    set_lu();
    #1;
    tests++; if (a_ctl !== CTL_STALL) begin failed++; $display("FAIL lu_stall got %b want %b", a_ctl, CTL_STALL); end
    tick();
    clear_inputs();
    #1;
    tests++; if (a_ctl !== CTL_DEF) begin failed++; $display("FAIL lu_release got %b want %b", a_ctl, CTL_DEF); end
    tests++; if (a_stall !== 32'd1) begin failed++; $display("FAIL lu_count got %0d want 1", a_stall); end
  endtask

  task automatic test_no_hazard();
    ex_mem_rden = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    #1;
    tests++; if (a_ctl !== CTL_DEF) begin failed++; $display("FAIL zero_reg got %b want %b", a_ctl, CTL_DEF); end
    ex_rt = 5'd5; id_rs = 5'd3; id_rt = 5'd5; id_uses_rt = 1'b0;
    #1;
    tests++; if (a_ctl !== CTL_DEF) begin failed++; $display("FAIL rt_unused got %b want %b", a_ctl, CTL_DEF); end
    ex_mem_rden = 1'b0; id_uses_rt = 1'b1;
    #1;
    tests++; if (a_ctl !== CTL_DEF) begin failed++; $display("FAIL not_load got %b want %b", a_ctl, CTL_DEF); end
    ex_mem_rden = 1'b1;
    #1;
    tests++; if (a_ctl !== CTL_STALL) begin failed++; $display("FAIL rt_used got %b want %b", a_ctl, CTL_STALL); end
    clear_inputs();
    tick();
    tests++; if (a_stall !== 32'd1) begin failed++; $display("FAIL no_hazard_count got %0d want 1", a_stall); end
  endtask

  task automatic test_multi_stall();
    set_lu();
    #1;
    tests++; if (b_ctl !== CTL_STALL) begin failed++; $display("FAIL ms_cyc1 got %b want %b", b_ctl, CTL_STALL); end
    tick();
    clear_inputs();
    #1;
    tests++; if (b_ctl !== CTL_STALL) begin failed++; $display("FAIL ms_cyc2 got %b want %b", b_ctl, CTL_STALL); end
    tick();
    tests++; if (b_ctl !== CTL_STALL) begin failed++; $display("FAIL ms_cyc3 got %b want %b", b_ctl, CTL_STALL); end
    tick();
    tests++; if (b_ctl !== CTL_DEF) begin failed++; $display("FAIL ms_done got %b want %b", b_ctl, CTL_DEF); end
    tests++; if (b_stall !== 4'd3) begin failed++; $display("FAIL ms_count got %0d want 3", b_stall); end
  endtask

  task automatic test_redirect_priority();
    set_lu();
    ex_pcsrc = 2'b01;
    #1;
    tests++; if (a_ctl !== CTL_FLUSH) begin failed++; $display("FAIL rd_prio got %b want %b", a_ctl, CTL_FLUSH); end
    tick();
    clear_inputs();
    #1;
    tests++; if (a_redir !== 32'd1 || a_stall !== 32'd0) begin failed++; $display("FAIL rd_prio_cnt got %0d/%0d want 1/0", a_redir, a_stall); end
    tests++; if (a_ctl !== CTL_DEF) begin failed++; $display("FAIL rd_single got %b want %b", a_ctl, CTL_DEF); end
  endtask

  task automatic test_back_to_back();
    ex_pcsrc = 2'b11;
    #1;
    tests++; if (b_ctl !== CTL_FLUSH) begin failed++; $display("FAIL b2b_cyc1 got %b want %b", b_ctl, CTL_FLUSH); end
    tick();
    tests++; if (b_ctl !== CTL_FLUSH) begin failed++; $display("FAIL b2b_cyc2 got %b want %b", b_ctl, CTL_FLUSH); end
    tick();
    ex_pcsrc = 2'b00;
    set_lu();
    #1;
    tests++; if (b_ctl !== CTL_FLUSH) begin failed++; $display("FAIL b2b_cyc3 got %b want %b", b_ctl, CTL_FLUSH); end
    clear_inputs();
    tick();
    tests++; if (b_ctl !== CTL_DEF) begin failed++; $display("FAIL b2b_done got %b want %b", b_ctl, CTL_DEF); end
    tests++; if (b_redir !== 4'd2 || b_stall !== 4'd0) begin failed++; $display("FAIL b2b_cnt got %0d/%0d want 2/0", b_redir, b_stall); end
  endtask

  task automatic test_stall_abort();
    set_lu();
    tick();
    clear_inputs();
    ex_pcsrc = 2'b10;
    #1;
    tests++; if (b_ctl !== CTL_FLUSH) begin failed++; $display("FAIL abort_ctl got %b want %b", b_ctl, CTL_FLUSH); end
    tick();
    ex_pcsrc = 2'b00;
    #1;
    tests++; if (b_stall !== 4'd1 || b_redir !== 4'd1) begin failed++; $display("FAIL abort_cnt got %0d/%0d want 1/1", b_stall, b_redir); end
    tests++; if (b_ctl !== CTL_FLUSH) begin failed++; $display("FAIL abort_redir got %b want %b", b_ctl, CTL_FLUSH); end
    tick();
    tests++; if (b_ctl !== CTL_DEF) begin failed++; $display("FAIL abort_done got %b want %b", b_ctl, CTL_DEF); end
  endtask

  task automatic test_saturate();
    set_lu();
    repeat (20) @(posedge clock);
    #1;
    clear_inputs();
    #1;
    tests++; if (b_stall !== 4'd15) begin failed++; $display("FAIL sat_b got %0d want 15", b_stall); end
    tests++; if (a_stall !== 32'd20) begin failed++; $display("FAIL nosat_a got %0d want 20", a_stall); end
  endtask

  task automatic test_reset_mid_stall();
    set_lu();
    tick();
    clear_inputs();
    #1;
    tests++; if (b_ctl !== CTL_STALL) begin failed++; $display("FAIL mid_pre got %b want %b", b_ctl, CTL_STALL); end
    reset = 1'b1;
    #1;
    tests++; if (b_ctl !== CTL_RST) begin failed++; $display("FAIL mid_rst_ctl got %b want %b", b_ctl, CTL_RST); end
    tests++; if (b_stall !== 4'd0 || b_redir !== 4'd0) begin failed++; $display("FAIL mid_rst_cnt got %0d/%0d want 0/0", b_stall, b_redir); end
    reset = 1'b0;
    #1;
    tests++; if (b_ctl !== CTL_DEF) begin failed++; $display("FAIL mid_after got %b want %b", b_ctl, CTL_DEF); end
    tick();
    tests++; if (b_stall !== 4'd0) begin failed++; $display("FAIL mid_no_pending got %0d want 0", b_stall); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_reset();
    test_multi_stall();
    test_reset();
    test_redirect_priority();
    test_reset();
    test_back_to_back();
    test_reset();
    test_stall_abort();
    test_reset();
    test_saturate();
    test_reset();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
